// File: rtl/mips_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_debug_pkg
// Description : Shared FSM encoding, command/reply codes and TX payload
//               helpers for the MIPS host-side debug unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_debug_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_CNT   = 4'd1,
        S_LOAD_BYTE  = 4'd2,
        S_LOAD_WRITE = 4'd3,
        S_RUN        = 4'd4,
        S_STEP       = 4'd5,
        S_STEP_CAP   = 4'd6,
        S_TX_SEND    = 4'd7,
        S_TX_WAIT    = 4'd8
    } dbg_state_e;

    localparam logic [7:0] c_cmd_load = 8'h4C;
    localparam logic [7:0] c_cmd_run  = 8'h43;
    localparam logic [7:0] c_cmd_step = 8'h53;

    localparam logic [7:0] c_rpl_ok   = 8'h4B;
    localparam logic [7:0] c_rpl_fin  = 8'h46;
    localparam logic [7:0] c_rpl_tmo  = 8'h54;
    localparam logic [7:0] c_rpl_unk  = 8'h3F;
    localparam logic [7:0] c_rpl_none = 8'h00;

    localparam int         c_tx_max_bytes = 9;
    localparam int         c_tx_w         = 8 * c_tx_max_bytes;
    localparam logic [3:0] c_len_one      = 4'd1;
    localparam logic [3:0] c_len_step     = 4'd5;
    localparam logic [3:0] c_len_run      = 4'd9;

    // Single-byte replies are left-aligned so the first byte sent is the MSB.
    function automatic logic [c_tx_w-1:0] tx_one(input logic [7:0] b);
        return {b, {(c_tx_w-8){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/debug_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : debug_tx_serializer
// Description : Parallel-load byte shift register with length, presenting the
//               head byte and start strobe to the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_tx_serializer #(
    parameter int MAX_BYTES = 9
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic [8*MAX_BYTES-1:0] i_load_data,
    input  logic [3:0]             i_load_len,
    input  logic                   i_send,
    input  logic                   i_done,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_last
);

    logic [8*MAX_BYTES-1:0] shift_q;
    logic [3:0]             len_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            shift_q <= '0;
            len_q   <= '0;
        end else if (i_load) begin
            shift_q <= i_load_data;
            len_q   <= i_load_len;
        end else if (i_done) begin
            shift_q <= {shift_q[8*MAX_BYTES-9:0], 8'h00};
            len_q   <= len_q - 4'd1;
        end
    end

    // Head byte only moves on i_done, so it stays stable for the whole send.
    assign o_tx_data  = shift_q[8*MAX_BYTES-1 -: 8];
    assign o_tx_start = i_send;
    assign o_last     = (len_q <= 4'd1);

endmodule
`default_nettype wire

// File: rtl/mips_debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_debug_unit
// Description : UART command decoder that loads, runs and single-steps the
//               MIPS core and returns results/status over the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_debug_unit
    import mips_debug_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_STEP   = 4,
    parameter int RUN_TIMEOUT = 1048576
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_tx_done,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_start,
    output logic                  o_step,
    input  logic [DATA_WIDTH-1:0] i_result_wb,
    input  logic                  i_finish
);

    dbg_state_e            state_q, state_d;
    logic [7:0]            nwords_q, nwords_d;
    logic [7:0]            index_q, index_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [31:0]           count_q, count_d;

    logic                  tx_load;
    logic [c_tx_w-1:0]     tx_payload;
    logic [3:0]            tx_len;
    logic                  tx_last;
    logic [31:0]           count_inc;

    assign count_inc = count_q + 32'd1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            nwords_q <= '0;
            index_q  <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            nwords_q <= nwords_d;
            index_q  <= index_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nwords_d   = nwords_q;
        index_d    = index_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        count_d    = count_q;
        tx_load    = 1'b0;
        tx_payload = '0;
        tx_len     = '0;
        case (state_q)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        c_cmd_load: begin
                            index_d = '0;
                            state_d = S_LOAD_CNT;
                        end
                        c_cmd_run: begin
                            count_d = '0;
                            if (i_finish) begin
                                tx_load    = 1'b1;
                                tx_payload = {32'h0, i_result_wb, c_rpl_fin};
                                tx_len     = c_len_run;
                                state_d    = S_TX_SEND;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                        c_cmd_step: begin
                            if (i_finish) begin
                                tx_load    = 1'b1;
                                tx_payload = tx_one(c_rpl_fin);
                                tx_len     = c_len_one;
                                state_d    = S_TX_SEND;
                            end else begin
                                state_d = S_STEP;
                            end
                        end
                        default: begin
                            tx_load    = 1'b1;
                            tx_payload = tx_one(c_rpl_unk);
                            tx_len     = c_len_one;
                            state_d    = S_TX_SEND;
                        end
                    endcase
                end
            end
            S_LOAD_CNT: begin
                if (i_rx_valid) begin
                    nwords_d = i_rx_data;
                    bcnt_d   = '0;
                    if (i_rx_data == 8'd0) begin
                        tx_load    = 1'b1;
                        tx_payload = tx_one(c_rpl_ok);
                        tx_len     = c_len_one;
                        state_d    = S_TX_SEND;
                    end else begin
                        state_d = S_LOAD_BYTE;
                    end
                end
            end
            S_LOAD_BYTE: begin
                if (i_rx_valid) begin
                    word_d = {word_q[DATA_WIDTH-9:0], i_rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_LOAD_WRITE;
                    end
                end
            end
            S_LOAD_WRITE: begin
                index_d = index_q + 8'd1;
                if ((index_q + 8'd1) == nwords_q) begin
                    tx_load    = 1'b1;
                    tx_payload = tx_one(c_rpl_ok);
                    tx_len     = c_len_one;
                    state_d    = S_TX_SEND;
                end else begin
                    state_d = S_LOAD_BYTE;
                end
            end
            S_RUN: begin
                count_d = count_inc;
                // A halt seen in the same cycle as the timeout reports 'F'.
                if (i_finish) begin
                    tx_load    = 1'b1;
                    tx_payload = {count_inc, i_result_wb, c_rpl_fin};
                    tx_len     = c_len_run;
                    state_d    = S_TX_SEND;
                end else if (count_inc == 32'(RUN_TIMEOUT)) begin
                    tx_load    = 1'b1;
                    tx_payload = {count_inc, i_result_wb, c_rpl_tmo};
                    tx_len     = c_len_run;
                    state_d    = S_TX_SEND;
                end
            end
            S_STEP: begin
                state_d = S_STEP_CAP;
            end
            S_STEP_CAP: begin
                tx_load    = 1'b1;
                tx_payload = {i_result_wb, (i_finish ? c_rpl_fin : c_rpl_none), 32'h0};
                tx_len     = c_len_step;
                state_d    = S_TX_SEND;
            end
            S_TX_SEND: begin
                state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (i_tx_done) begin
                    state_d = tx_last ? S_IDLE : S_TX_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_loading     = 1'b0;
        o_start       = 1'b0;
        o_step        = 1'b0;
        o_instruccion = '0;
        o_address     = '0;
        case (state_q)
            S_LOAD_WRITE: begin
                o_loading     = 1'b1;
                o_instruccion = word_q;
                o_address     = DATA_WIDTH'(index_q) * DATA_WIDTH'(ADDR_STEP);
            end
            S_RUN:   o_start = 1'b1;
            S_STEP:  o_step  = 1'b1;
            default: ;
        endcase
    end

    debug_tx_serializer #(
        .MAX_BYTES (c_tx_max_bytes)
    ) u_tx_ser (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (tx_load),
        .i_load_data (tx_payload),
        .i_load_len  (tx_len),
        .i_send      (state_q == S_TX_SEND),
        .i_done      ((state_q == S_TX_WAIT) && i_tx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_last      (tx_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_debug_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_debug_unit
// Description : Scoreboard bench for mips_debug_unit (default and short-timeout
//               instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_debug_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, tx_start, loading, start, step, finish;
    logic        tx_done = 1'b0;
    logic [31:0] instr, addr, result;

    // Instance B: RUN_TIMEOUT = 16
    logic [7:0]  rx_data_b, tx_data_b;
    logic        rx_valid_b, tx_start_b, loading_b, start_b, step_b, finish_b;
    logic        tx_done_b = 1'b0;
    logic [31:0] instr_b, addr_b, result_b;

    mips_debug_unit dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_tx_done(tx_done),
        .o_tx_data(tx_data), .o_tx_start(tx_start),
        .o_instruccion(instr), .o_address(addr), .o_loading(loading),
        .o_start(start), .o_step(step),
        .i_result_wb(result), .i_finish(finish)
    );

    mips_debug_unit #(.RUN_TIMEOUT(16)) dut_b (
        .i_clock(clk), .i_reset(rst_n),
        .i_rx_data(rx_data_b), .i_rx_valid(rx_valid_b), .i_tx_done(tx_done_b),
        .o_tx_data(tx_data_b), .o_tx_start(tx_start_b),
        .o_instruccion(instr_b), .o_address(addr_b), .o_loading(loading_b),
        .o_start(start_b), .o_step(step_b),
        .i_result_wb(result_b), .i_finish(finish_b)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0]  exp_tx_a[$];
    logic [7:0]  exp_tx_b[$];
    logic [63:0] exp_ld[$];
    int ld_cnt = 0, start_cnt = 0, step_cnt = 0, start_cnt_b = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Monitor A: pops expected TX bytes and load writes whenever the DUT presents them
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            if (exp_tx_a.size() == 0) fail("tx_extra_a", {56'h0, tx_data});
            else check("tx_byte_a", {56'h0, tx_data}, {56'h0, exp_tx_a.pop_front()});
        end
        if (loading) begin
            ld_cnt++;
            if (exp_ld.size() == 0) fail("load_extra", {addr, instr});
            else check("load_word", {addr, instr}, exp_ld.pop_front());
        end
        if (start) start_cnt++;
        if (step)  step_cnt++;
        if ($countones({start, step, loading}) > 1) fail("ctl_exclusive", {61'h0, start, step, loading});
    end

    // Monitor B
    initial forever begin
        @(negedge clk);
        if (tx_start_b) begin
            if (exp_tx_b.size() == 0) fail("tx_extra_b", {56'h0, tx_data_b});
            else check("tx_byte_b", {56'h0, tx_data_b}, {56'h0, exp_tx_b.pop_front()});
        end
        if (start_b) start_cnt_b++;
    end

    // Transmitter models: i_tx_done four cycles after each start
    initial begin
        int dly = -1;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_start) dly = 4;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) begin tx_done = 1'b1; dly = -1; end
            end
        end
    end

    initial begin
        int dly = -1;
        forever begin
            @(negedge clk);
            tx_done_b = 1'b0;
            if (tx_start_b) dly = 4;
            else if (dly > 0) begin
                dly--;
                if (dly == 0) begin tx_done_b = 1'b1; dly = -1; end
            end
        end
    end

    task automatic send_a(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        @(negedge clk);
        rx_data_b  = b;
        rx_valid_b = 1'b1;
        @(negedge clk);
        rx_valid_b = 1'b0;
    endtask

    task automatic drain(input int sel);
        int k = 0;
        while (((sel == 0) ? (exp_tx_a.size() + exp_ld.size()) : exp_tx_b.size()) != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            fail("drain_timeout", 64'(sel));
            exp_tx_a.delete();
            exp_tx_b.delete();
            exp_ld.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_loading"}, {63'h0, loading},  64'h0);
        check({tag, "_start"},   {63'h0, start},    64'h0);
        check({tag, "_step"},    {63'h0, step},     64'h0);
        check({tag, "_tx_start"},{63'h0, tx_start}, 64'h0);
        check({tag, "_tx_data"}, {56'h0, tx_data},  64'h0);
        check({tag, "_instr"},   {32'h0, instr},    64'h0);
        check({tag, "_addr"},    {32'h0, addr},     64'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] load_seq[10];
        int c0;
        rst_n = 1'b0;
        rx_data = '0;   rx_valid = 1'b0;   result = '0;   finish = 1'b0;
        rx_data_b = '0; rx_valid_b = 1'b0; result_b = '0; finish_b = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Load two words
        load_seq = '{8'h4C, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
        exp_ld.push_back({32'h0, 32'h20010005});
        exp_ld.push_back({32'h4, 32'hFC000000});
        exp_tx_a.push_back(8'h4B);
        c0 = ld_cnt;
        foreach (load_seq[i]) send_a(load_seq[i]);
        drain(0);
        check("load_count", 64'(ld_cnt - c0), 64'd2);

        // Continuous run, halt during the 37th run cycle
        result = 32'h0000002A;
        finish = 1'b0;
        c0 = start_cnt;
        foreach (load_seq[i]) load_seq[i] = 8'h00;
        exp_tx_a.push_back(8'h00); exp_tx_a.push_back(8'h00);
        exp_tx_a.push_back(8'h00); exp_tx_a.push_back(8'h25);
        exp_tx_a.push_back(8'h00); exp_tx_a.push_back(8'h00);
        exp_tx_a.push_back(8'h00); exp_tx_a.push_back(8'h2A);
        exp_tx_a.push_back(8'h46);
        send_a(8'h43);
        repeat (36) @(negedge clk);
        finish = 1'b1;
        drain(0);
        check("run_cycles", 64'(start_cnt - c0), 64'd37);

        // Single step, core not halted
        finish = 1'b0;
        result = 32'h12345678;
        c0 = step_cnt;
        exp_tx_a.push_back(8'h12); exp_tx_a.push_back(8'h34);
        exp_tx_a.push_back(8'h56); exp_tx_a.push_back(8'h78);
        exp_tx_a.push_back(8'h00);
        send_a(8'h53);
        drain(0);
        check("step_pulses", 64'(step_cnt - c0), 64'd1);

        // Single step on a halted core: 'F' only, no pulse
        finish = 1'b1;
        c0 = step_cnt;
        exp_tx_a.push_back(8'h46);
        send_a(8'h53);
        drain(0);
        check("step_halted_pulses", 64'(step_cnt - c0), 64'd0);

        // Unknown byte, then bytes arriving during TX_WAIT are dropped
        exp_tx_a.push_back(8'h3F);
        send_a(8'h7A);
        c0 = 0;
        while (!tx_start && c0 < 100) begin @(negedge clk); c0++; end
        send_a(8'h43);
        send_a(8'h7A);
        drain(0);

        // Timeout on the short-timeout instance
        result_b = 32'hDEADBEEF;
        c0 = start_cnt_b;
        exp_tx_b.push_back(8'h00); exp_tx_b.push_back(8'h00);
        exp_tx_b.push_back(8'h00); exp_tx_b.push_back(8'h10);
        exp_tx_b.push_back(8'hDE); exp_tx_b.push_back(8'hAD);
        exp_tx_b.push_back(8'hBE); exp_tx_b.push_back(8'hEF);
        exp_tx_b.push_back(8'h54);
        send_b(8'h43);
        drain(1);
        check("timeout_cycles", 64'(start_cnt_b - c0), 64'd16);

        // Reset in the middle of a load, then an empty load
        finish = 1'b0;
        c0 = ld_cnt;
        send_a(8'h4C);
        send_a(8'h01);
        send_a(8'hAA);
        send_a(8'hBB);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_tx_a.push_back(8'h4B);
        send_a(8'h4C);
        send_a(8'h00);
        drain(0);
        check("empty_load_writes", 64'(ld_cnt - c0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Host-side controller driving the MIPS core's load/run/step interface, and the other end of the core's i_instruccion/i_address/i_loading/i_start/i_step / o_result_wb/o_finish port set.
- Decodes a byte command stream from the UART receiver, writes program words into instruction memory, and runs or single-steps the pipeline.
- Serialises write-back result, cycle count and status back to the UART transmitter.
- Sits between the UART RX/TX and the MIPS top in the board-level wrapper.

Parameters:
- DATA_WIDTH, 32, word width; must be 32, since byte packing is fixed at 4 bytes.
- ADDR_STEP, 4, address increment per loaded word (byte addressing).
- RUN_TIMEOUT, 1048576, maximum cycles in continuous run before forced stop.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle pulse: i_rx_data valid.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- o_tx_data  out  8  byte to transmit, stable from o_tx_start until i_tx_done.
- o_tx_start  out  1  one-cycle pulse: begin transmitting o_tx_data.
- o_instruccion  out  DATA_WIDTH  program word to core.
- o_address  out  DATA_WIDTH  instruction memory byte address.
- o_loading  out  1  one-cycle write strobe to instruction memory.
- o_start  out  1  level: continuous run enable.
- o_step  out  1  one-cycle single-step pulse.
- i_result_wb  in  DATA_WIDTH  core write-back value.
- i_finish  in  1  core halt reached.

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs 0, FSM in IDLE, counters, shift registers and captured data cleared. Reset asserted mid-operation aborts at once; partially received words and pending TX bytes are discarded.
- Commands, recognised only in IDLE on i_rx_valid:
  - 0x4C 'L': load program.
  - 0x43 'C': continuous run.
  - 0x53 'S': single step.
  - Any other byte: reply 0x3F '?'.
- i_rx_valid outside IDLE, LOAD_CNT and LOAD_BYTE is ignored (byte dropped).
- FSM states: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, STEP_CAP, TX_SEND, TX_WAIT.
- Load:
  - LOAD_CNT takes the next byte as word count N (0..255).
  - N=0: go straight to TX of 0x4B 'K'.
  - LOAD_BYTE collects 4 bytes MSB-first into a shift register, then moves to LOAD_WRITE.
  - LOAD_WRITE holds o_loading=1 for exactly one cycle with o_instruccion=word and o_address=ADDR_STEP*index (index starts at 0 per 'L' command), then increments index.
  - After N words, reply 'K'.
- Run:
  - If i_finish=1 at the command, skip RUN: count=0, status 'F'.
  - Otherwise o_start=1 from the cycle after the command byte. The 32-bit cycle counter increments every cycle o_start=1.
  - First cycle i_finish=1 while in RUN: o_start drops on the next edge, i_result_wb is captured on that edge, status = 0x46 'F'.
  - If the counter reaches RUN_TIMEOUT first: stop identically, status = 0x54 'T'.
  - If i_finish and timeout occur in the same cycle, 'F' wins.
  - Reply is 9 bytes: count[31:24..7:0], result[31:24..7:0], status.
- Step:
  - If i_finish=1 at the command, reply 'F' only and issue no pulse.
  - Otherwise STEP drives o_step=1 for one cycle. STEP_CAP captures i_result_wb one cycle after the pulse. Status = 'F' if i_finish=1 in STEP_CAP, else 0x00.
  - Reply is 5 bytes: result MSB-first, then status.
- TX:
  - TX_SEND emits a one-cycle o_tx_start with the current byte.
  - TX_WAIT holds o_tx_data until i_tx_done, then advances, or returns to IDLE after the last byte.
  - An i_tx_done arriving outside TX_WAIT is ignored.
  - Byte count register is 4 bits (max 9).
- o_start, o_step and o_loading are never asserted simultaneously.

Decomposition:
- Shared package mips_debug_pkg holds:
  - FSM state encoding.
  - Command codes 'L','C','S'.
  - Reply codes 'K','F','T','?', 0x00.
- Natural sub-module: debug_tx_serializer, a 9-byte parallel-load shift register with length plus the start/done handshake, instantiated once.

Test Plan:
- Load two words: 'L',0x02,0x20,0x01,0x00,0x05,0xFC,0x00,0x00,0x00. Expect o_loading pulses with (addr 0x0, 0x20010005) and (addr 0x4, 0xFC000000), then TX 'K'.
- 'C' with i_finish rising after 37 o_start cycles and i_result_wb=0x0000002A. Expect o_start high for 37 cycles, then TX 00 00 00 25 00 00 00 2A 46.
- 'S' with i_result_wb=0x12345678 after the pulse and i_finish=0. Expect a single o_step pulse, then TX 12 34 56 78 00. Repeat with i_finish=1 beforehand: expect TX 46 only and no o_step.
- 'C' with RUN_TIMEOUT=16 and i_finish held 0. Expect o_start for exactly 16 cycles, then TX 00 00 00 10 <result 4 bytes> 54.
- Byte 0x7A in IDLE: expect TX 3F. Extra rx bytes sent during TX_WAIT produce no effect.
- Pull i_reset low after 'L',0x01,0xAA,0xBB: expect all outputs 0 immediately. After release, a fresh 'L',0x00 returns 'K' and no o_loading pulse occurs.
